// File: rtl/call_stack.sv
// call_stack: LIFO frame store for the recursive Fibonacci engine.
//
// This block is the responder end of the stack controller's push/pop
// protocol. It accepts one request at a time while idle. It stores or returns
// a packed call frame {ret[1:0], n[7:0], flag[7:0]}, and it acknowledges every
// accepted request, including rejected ones, with a one-cycle done pulse.
//
// Build option:
//   CALL_STACK_GUARD_EN  When defined, overflow pushes and underflow pops are
//                        rejected and set err. When undefined, there is no
//                        guard: the pointer wraps modulo 2*DEPTH, and
//                        overflow/underflow are left to the software contract.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   push       push request (sampled in IDLE)
//   pop        pop request (sampled in IDLE)
//   push_data  frame to store, sampled with push
//   pop_data   frame returned by the last successful pop (registered)
//   done       one-cycle acknowledge of each accepted request
//   empty      count == 0
//   full       count == DEPTH
//   count      number of stored frames
//   err        sticky error flag, cleared only by reset
module call_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     done,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             illegal;
  logic             do_push;
  logic             do_pop;
  logic             reject;
  logic             is_full;
  logic             is_empty;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign is_full  = (sp == SP_FULL);
  assign is_empty = (sp == '0);

  // The low pointer bits address the memory. An unguarded overflow therefore
  // lands on slot 0, and an unguarded underflow reads slot DEPTH-1.
  assign wr_idx = sp[AW-1:0];
  assign rd_idx = AW'(sp - CW'(1));

  always_comb begin
    accept  = (state == IDLE) && (push || pop);
    illegal = push && pop;
`ifdef CALL_STACK_GUARD_EN
    do_push = accept && push && !pop && !is_full;
    do_pop  = accept && pop && !push && !is_empty;
    reject  = accept && ((push && !pop && is_full) || (pop && !push && is_empty));
`else
    do_push = accept && push && !pop;
    do_pop  = accept && pop && !push;
    reject  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + CW'(1);
    end else if (do_pop) begin
      sp <= sp - CW'(1);
    end
  end

  // Frame storage is not reset. Slots at or above sp hold stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data <= '0;
    end else if (do_pop) begin
      pop_data <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && (illegal || reject)) begin
      err <= 1'b1;
    end
  end

  assign done  = (state == ACK);
  assign count = sp;
  assign empty = is_empty;
  assign full  = is_full;

endmodule

// File: doc/call_stack.md
# call_stack

Hardware LIFO frame store for the recursive Fibonacci engine: the responder end of the stack controller's push/pop protocol. It accepts one push or pop request at a time, stores or returns a packed call frame (return code, `n`, `flag`), and acknowledges each operation with a one-cycle `done` pulse. It sits between the stack controller and the datapath; the controller issues the requests and the datapath supplies and consumes frame contents.

## Interface
- `DEPTH`, default 16: number of frames; power of two, at least 2.
- `WIDTH`, default 18: frame width, packed as {ret[1:0], n[7:0], flag[7:0]}.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `push`, input, 1: push request, sampled in IDLE.
- `pop`, input, 1: pop request, sampled in IDLE.
- `push_data`, input, WIDTH: frame to store; sampled with `push`.
- `pop_data`, output, WIDTH: registered frame returned by the last successful pop; holds its value otherwise.
- `done`, output, 1: one-cycle acknowledge of every accepted request, including rejected ones.
- `empty`, output, 1: `count == 0`.
- `full`, output, 1: `count == DEPTH`.
- `count`, output, clog2(DEPTH)+1: number of stored frames.
- `err`, output, 1: sticky error flag; cleared only by reset.

## Operation
- State machine has two states, IDLE and ACK.
  - IDLE → ACK on any accepted request.
  - ACK → IDLE unconditionally after one cycle.
- `done` is high exactly in ACK.
- All requests arriving in ACK are ignored. They are not queued.
- Stack pointer `sp` (= `count`) indexes the next free slot.
- Accepted push, not full:
  - `mem[sp] <= push_data`.
  - `sp <= sp + 1`.
- Accepted pop, not empty:
  - `pop_data <= mem[sp-1]`.
  - `sp <= sp - 1`.
- `push` and `pop` both high in IDLE: illegal.
  - Neither operation is performed.
  - `sp` and `pop_data` are unchanged.
  - `err` is set.
  - `done` still pulses.
- Push when full (overflow) or pop when empty (underflow): handled per Configuration.
- Memory is not reset; slots at or above `sp` are undefined.
- Reset values:
  - `sp = 0`, state IDLE.
  - `done = 0`, `pop_data = 0`, `err = 0`.
  - `empty = 1`, `full = 0`, `count = 0`.
- Reset asserted mid-operation, including during ACK, aborts the operation at once. Any in-flight frame is discarded.

## Timing
- Request sampled on rising edge N while in IDLE.
- `done`, updated `pop_data`, `count`, `empty` and `full` are all valid after edge N, for cycle N+1.
- `done` deasserts after edge N+1.
- Earliest next accepted request is at edge N+2, so maximum throughput is one operation per 2 cycles.
- The controller holds `push`/`pop` for at least one cycle. Holding a request through ACK does not repeat it; a request still high when the block returns to IDLE is a new request.
- A push at edge N followed by a pop at edge N+2 returns the pushed frame at N+3 (write-then-read, no forwarding needed).
- `full`, `empty` and `count` are registered-derived; there is no combinational path from the inputs.
- `rst_n` deassertion is synchronized by the integrator. The first request is accepted on the first edge after release.

## Configuration
- Macro `CALL_STACK_GUARD_EN`.
- Defined:
  - Overflow push and underflow pop are rejected.
  - `sp`, `mem` and `pop_data` are unchanged.
  - `err` is set.
  - `done` still pulses.
- Undefined:
  - No guard logic and no overflow/underflow detection; `err` is driven only by the simultaneous push+pop case.
  - Overflow push overwrites `mem[0]`.
  - Underflow pop reads `mem[DEPTH-1]`.
  - Counter wraps modulo `2*DEPTH`, so `full`/`empty` become meaningless after a wrap.
  - The software contract forbids both cases.

## Test plan
- Reset, then push 0x2_05_01 → `done` high for exactly 1 cycle, `count = 1`, `empty = 0`. Then pop → `pop_data = 0x2_05_01`, `count = 0`, `empty = 1`, `err = 0`.
- Push frames 1..16 back to back, each issued in IDLE → `full = 1` after the 16th. Then 16 pops → `pop_data` sequence 16..1, `empty = 1`.
- With `CALL_STACK_GUARD_EN` defined:
  - Push a 17th frame when full → `count` stays 16, `err = 1`.
  - Pop 16 frames → unchanged contents 16..1.
  - Pop on empty → `pop_data` retains the last value, `err = 1`.
- `push` and `pop` high together in IDLE → `done` pulses, `count` and `pop_data` unchanged, `err = 1`.
- Hold `push` high for 4 cycles with `push_data = 0x00A` → exactly 2 pushes accepted (edges N and N+2), `count = 2`.
- Assert `rst_n` low during ACK after a push → `done = 0` immediately, `count = 0`, `err = 0`, `pop_data = 0`. Then a push after release works normally.
